// File: rtl/rst_sequencer.sv
// Releases NUM_STAGES downstream domain resets one by one, in index order. Each release
// follows a settle delay and waits on the ack of the stage released before it.
// Optional ack timeout is enabled by defining RSTSEQ_ACK_TIMEOUT_EN.
module rst_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DLY   = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int STG_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic [STG_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  timeout_err
);

  if (NUM_STAGES < 1) begin : g_bad_num_stages
    $error("rst_sequencer: NUM_STAGES must be >= 1");
  end
  if (STAGE_DLY < 1) begin : g_bad_stage_dly
    $error("rst_sequencer: STAGE_DLY must be >= 1");
  end
  if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
    $error("rst_sequencer: ACK_TIMEOUT must be >= 1");
  end

  localparam int CNT_W = $clog2(STAGE_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [STG_W-1:0] LAST_IDX = STG_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    COUNT    = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STG_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  seq_done_q, seq_done_d;
  logic                  advance;

`ifdef RSTSEQ_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  // A software request restarts from HOLD exactly like power-on; it is ignored while
  // already in HOLD since the next edge starts counting anyway.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stage_rst_n_d = stage_rst_n_q;
    busy_d        = busy_q;
    seq_done_d    = seq_done_q;
    advance       = 1'b0;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif

    if (sw_rst_req && (state_q != HOLD)) begin
      state_d       = HOLD;
      cnt_d         = '0;
      idx_d         = '0;
      stage_rst_n_d = '0;
      busy_d        = 1'b1;
      seq_done_d    = 1'b0;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
      tmo_cnt_d     = '0;
      timeout_err_d = 1'b0;
`endif
    end else begin
      case (state_q)
        HOLD: begin
          state_d = COUNT;
          cnt_d   = '0;
        end

        COUNT: begin
          if (cnt_q == CNT_LAST) begin
            stage_rst_n_d[idx_q] = 1'b1;
            state_d              = WAIT_ACK;
            cnt_d                = '0;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
            tmo_cnt_d            = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        WAIT_ACK: begin
          advance = stage_ack[idx_q];
`ifdef RSTSEQ_ACK_TIMEOUT_EN
          // A real ack on the expiry edge wins, so the error flag is only set when the
          // domain genuinely never answered.
          if (!stage_ack[idx_q]) begin
            if (tmo_cnt_q == TMO_LAST) begin
              advance       = 1'b1;
              timeout_err_d = 1'b1;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
          end
`endif
          if (advance) begin
            if (idx_q == LAST_IDX) begin
              state_d       = DONE;
              busy_d        = 1'b0;
              seq_done_d    = 1'b1;
              stage_rst_n_d = '1;
            end else begin
              idx_d   = idx_q + 1'b1;
              cnt_d   = '0;
              state_d = COUNT;
            end
          end
        end

        DONE: begin
          busy_d        = 1'b0;
          seq_done_d    = 1'b1;
          stage_rst_n_d = '1;
        end

        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      stage_rst_n_q <= '0;
      busy_q        <= 1'b1;
      seq_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      stage_rst_n_q <= stage_rst_n_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
    end
  end

`ifdef RSTSEQ_ACK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign stage_rst_n = stage_rst_n_q;
  assign cur_stage   = idx_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed self-checking bench for rst_sequencer at default parameters; expected edge
// numbers are hand-computed relative to E0, the first edge with rst released.
module tb_rst_sequencer;

  logic       clk;
  logic       rst;
  logic       sw_rst_req;
  logic [3:0] stage_ack;
  logic [3:0] stage_rst_n;
  logic [1:0] cur_stage;
  logic       busy;
  logic       seq_done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;

  rst_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw_rst_req),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .cur_stage   (cur_stage),
    .busy        (busy),
    .seq_done    (seq_done),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic sw, input logic [3:0] ack);
    rst        = r;
    sw_rst_req = sw;
    stage_ack  = ack;
  endtask

  // Returns just after edge E<k> of the current sequence.
  task automatic waitEdge(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic startSeq(input logic [3:0] ack);
    applyStimulus(1'b1, 1'b0, ack);
    base = cyc + 1;
  endtask

  task automatic hardReset(input logic [3:0] ack);
    applyStimulus(1'b0, 1'b0, ack);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rstn"}, 32'(stage_rst_n), 32'h0);
    checkOutput({tag, "_stage"}, 32'(cur_stage), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h1);
    checkOutput({tag, "_done"}, 32'(seq_done), 32'h0);
    checkOutput({tag, "_terr"}, 32'(timeout_err), 32'h0);
  endtask

  // Nominal timing with all acks high: releases at E16, E33, E50, E67, DONE at E68.
  task automatic checkNominal(input string tag);
    waitEdge(15); checkOutput({tag, "_e15"}, 32'(stage_rst_n), 32'h0);
    waitEdge(16); checkOutput({tag, "_e16"}, 32'(stage_rst_n), 32'h1);
                  checkOutput({tag, "_e16_stage"}, 32'(cur_stage), 32'h0);
    waitEdge(17); checkOutput({tag, "_e17_stage"}, 32'(cur_stage), 32'h1);
    waitEdge(32); checkOutput({tag, "_e32"}, 32'(stage_rst_n), 32'h1);
    waitEdge(33); checkOutput({tag, "_e33"}, 32'(stage_rst_n), 32'h3);
    waitEdge(50); checkOutput({tag, "_e50"}, 32'(stage_rst_n), 32'h7);
    waitEdge(66); checkOutput({tag, "_e66"}, 32'(stage_rst_n), 32'h7);
    waitEdge(67); checkOutput({tag, "_e67"}, 32'(stage_rst_n), 32'hF);
                  checkOutput({tag, "_e67_done"}, 32'(seq_done), 32'h0);
                  checkOutput({tag, "_e67_busy"}, 32'(busy), 32'h1);
    waitEdge(68); checkOutput({tag, "_e68_done"}, 32'(seq_done), 32'h1);
                  checkOutput({tag, "_e68_busy"}, 32'(busy), 32'h0);
                  checkOutput({tag, "_e68_stage"}, 32'(cur_stage), 32'h3);
  endtask

  initial begin
    // Power-on sequence with every ack high
    applyStimulus(1'b0, 1'b0, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    checkResetState("t1_reset");
    startSeq(4'hF);
    checkNominal("t1");
    waitEdge(75);
    checkOutput("t1_done_hold", 32'(stage_rst_n), 32'hF);

    // Software re-sequence from DONE; E0 is the edge after the request edge
    applyStimulus(1'b1, 1'b1, 4'hF);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 4'hF);
    checkOutput("t3_sw_rstn", 32'(stage_rst_n), 32'h0);
    checkOutput("t3_sw_done", 32'(seq_done), 32'h0);
    checkOutput("t3_sw_busy", 32'(busy), 32'h1);
    checkOutput("t3_sw_stage", 32'(cur_stage), 32'h0);
    startSeq(4'hF);
    checkNominal("t3");

    // Stage 1 ack withheld for 100 cycles after its release
    hardReset(4'hD);
    checkResetState("t2_reset");
    startSeq(4'hD);
    waitEdge(33);  checkOutput("t2_e33", 32'(stage_rst_n), 32'h3);
    waitEdge(133); checkOutput("t2_e133", 32'(stage_rst_n), 32'h3);
                   checkOutput("t2_e133_stage", 32'(cur_stage), 32'h1);
                   checkOutput("t2_e133_busy", 32'(busy), 32'h1);
    applyStimulus(1'b1, 1'b0, 4'hF);
    waitEdge(149); checkOutput("t2_e149", 32'(stage_rst_n), 32'h3);
    waitEdge(150); checkOutput("t2_e150", 32'(stage_rst_n), 32'h7);

    // rst dropped on the edge right after stage 1 releases
    hardReset(4'hF);
    startSeq(4'hF);
    waitEdge(33);  checkOutput("t4_e33", 32'(stage_rst_n), 32'h3);
    applyStimulus(1'b0, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    checkResetState("t4_mid");
    startSeq(4'hF);
    waitEdge(15);  checkOutput("t4_e15", 32'(stage_rst_n), 32'h0);
    waitEdge(16);  checkOutput("t4_e16", 32'(stage_rst_n), 32'h1);
    waitEdge(17);  checkOutput("t4_e17_stage", 32'(cur_stage), 32'h1);

    // Only the current stage's ack matters
    hardReset(4'hE);
    startSeq(4'hE);
    waitEdge(16);  checkOutput("t5_e16", 32'(stage_rst_n), 32'h1);
    waitEdge(60);  checkOutput("t5_e60", 32'(stage_rst_n), 32'h1);
                   checkOutput("t5_e60_stage", 32'(cur_stage), 32'h0);
                   checkOutput("t5_e60_busy", 32'(busy), 32'h1);

    // Stage 2 never acks
    hardReset(4'hB);
    startSeq(4'hB);
    waitEdge(50);  checkOutput("t6_e50", 32'(stage_rst_n), 32'h7);
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    waitEdge(113); checkOutput("t6_e113_terr", 32'(timeout_err), 32'h0);
                   checkOutput("t6_e113_stage", 32'(cur_stage), 32'h2);
    waitEdge(114); checkOutput("t6_e114_terr", 32'(timeout_err), 32'h1);
                   checkOutput("t6_e114_stage", 32'(cur_stage), 32'h3);
    waitEdge(129); checkOutput("t6_e129", 32'(stage_rst_n), 32'h7);
    waitEdge(130); checkOutput("t6_e130", 32'(stage_rst_n), 32'hF);
    waitEdge(131); checkOutput("t6_e131_done", 32'(seq_done), 32'h1);
                   checkOutput("t6_e131_terr", 32'(timeout_err), 32'h1);
    applyStimulus(1'b1, 1'b1, 4'hB);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 4'hB);
    checkOutput("t6_sw_terr", 32'(timeout_err), 32'h0);
`else
    waitEdge(200); checkOutput("t6_e200", 32'(stage_rst_n), 32'h7);
                   checkOutput("t6_e200_terr", 32'(timeout_err), 32'h0);
                   checkOutput("t6_e200_busy", 32'(busy), 32'h1);
                   checkOutput("t6_e200_stage", 32'(cur_stage), 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
